irq_trap_sequencer: RTL and testbench

Interrupt arbiter and trap-entry sequencer that sits between external interrupt sources, the pipeline and the CSR file. It latches edge-triggered requests, masks them with the CSR enable state, and picks one winner. It then sequences a trap entry: capture mepc and mcause, and redirect fetch to the mtvec-derived vector. On mret it sequences the return redirect to mepc.

---
 rtl/irq_pkg.sv | 23 ++
 rtl/irq_trap_sequencer_if.sv | 37 +++
 rtl/irq_priority_pick.sv | 47 ++++
 rtl/irq_trap_sequencer.sv | 167 ++++++++++++++++
 tb/tb_irq_trap_sequencer.sv | 315 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/irq_pkg.sv
// Shared types and constants for the interrupt trap-entry sequencer.
package irq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        ENTER,
        HANDLER,
        RET
    } trap_state_e;

    localparam logic [1:0] MTVEC_DIRECT   = 2'b00;
    localparam logic [1:0] MTVEC_VECTORED = 2'b01;

    localparam int unsigned CAUSE_BASE_DEFAULT = 16;
    localparam int unsigned NUM_IRQ_DEFAULT    = 4;

    // Index width for a source vector; a single source still needs one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/irq_trap_sequencer_if.sv
// Bundle of core/CSR-facing signals around the trap sequencer.
interface irq_trap_sequencer_if #(
    parameter int unsigned NUM_IRQ = irq_pkg::NUM_IRQ_DEFAULT
);
    logic [NUM_IRQ-1:0] irq_i;
    logic [NUM_IRQ-1:0] irq_en;
    logic               glob_ie;
    logic [31:0]        mtvec;
    logic [31:0]        mepc_i;
    logic [31:0]        pc_i;
    logic               is_mret;
    logic               pipe_ready;

    logic [NUM_IRQ-1:0] irq_ack;
    logic               trap_pending;
    logic               redirect_valid;
    logic [31:0]        redirect_pc;
    logic               mepc_wr;
    logic [31:0]        mepc_wdata;
    logic               mcause_wr;
    logic [31:0]        mcause_wdata;
    logic               in_handler;

    // Sequencer side
    modport master (
        input  irq_i, irq_en, glob_ie, mtvec, mepc_i, pc_i, is_mret, pipe_ready,
        output irq_ack, trap_pending, redirect_valid, redirect_pc,
               mepc_wr, mepc_wdata, mcause_wr, mcause_wdata, in_handler
    );

    // Core / CSR side
    modport slave (
        output irq_i, irq_en, glob_ie, mtvec, mepc_i, pc_i, is_mret, pipe_ready,
        input  irq_ack, trap_pending, redirect_valid, redirect_pc,
               mepc_wr, mepc_wdata, mcause_wr, mcause_wdata, in_handler
    );
endinterface

// File: rtl/irq_priority_pick.sv
// Picks one eligible interrupt index. Round-robin from `start` when
// IRQ_ROUND_ROBIN_EN is defined, otherwise fixed lowest-index priority.
module irq_priority_pick
    import irq_pkg::*;
#(
    parameter int unsigned NUM_IRQ = NUM_IRQ_DEFAULT,
    parameter int unsigned IW      = idx_width(NUM_IRQ)
) (
    input  logic [NUM_IRQ-1:0] eligible,
    input  logic [IW-1:0]      start,
    output logic               valid,
    output logic [IW-1:0]      idx
);

`ifdef IRQ_ROUND_ROBIN_EN
    logic [IW-1:0] pos;

    // First eligible index walking upward from start, wrapping at NUM_IRQ
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        pos   = '0;
        for (int unsigned k = 0; k < NUM_IRQ; k++) begin
            pos = IW'((32'(start) + k) % NUM_IRQ);
            if (!valid && eligible[pos]) begin
                valid = 1'b1;
                idx   = pos;
            end
        end
    end
`else
    logic unused_start;
    assign unused_start = ^start;

    always_comb begin
        valid = 1'b0;
        idx   = '0;
        for (int unsigned k = 0; k < NUM_IRQ; k++) begin
            if (!valid && eligible[IW'(k)]) begin
                valid = 1'b1;
                idx   = IW'(k);
            end
        end
    end
`endif

endmodule

// File: rtl/irq_trap_sequencer.sv
// Interrupt arbiter and trap entry/return sequencer.
// Build option: IRQ_ROUND_ROBIN_EN selects round-robin arbitration.
module irq_trap_sequencer
    import irq_pkg::*;
#(
    parameter int unsigned NUM_IRQ    = NUM_IRQ_DEFAULT,
    parameter int unsigned CAUSE_BASE = CAUSE_BASE_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    irq_trap_sequencer_if.master bus
);

    localparam int unsigned IW = idx_width(NUM_IRQ);

    trap_state_e        state;
    trap_state_e        state_nxt;
    logic [NUM_IRQ-1:0] irq_q;
    logic [NUM_IRQ-1:0] pending;
    logic [NUM_IRQ-1:0] rising;
    logic [NUM_IRQ-1:0] eligible;
    logic [IW-1:0]      sel;
    logic               sel_load;
    logic [IW-1:0]      start;
    logic               pick_valid;
    logic [IW-1:0]      pick_idx;
    logic [31:0]        vector;
    logic [31:0]        vec_base;

    logic [NUM_IRQ-1:0] ack_c;
    logic               trap_pending_c;
    logic               redirect_valid_c;
    logic [31:0]        redirect_pc_c;
    logic               mepc_wr_c;
    logic [31:0]        mepc_wdata_c;
    logic               mcause_wr_c;
    logic [31:0]        mcause_wdata_c;
    logic               in_handler_c;

    assign rising   = bus.irq_i & ~irq_q;
    assign eligible = pending & bus.irq_en & {NUM_IRQ{bus.glob_ie}};

`ifdef IRQ_ROUND_ROBIN_EN
    logic [IW-1:0] last_granted;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_granted <= IW'(NUM_IRQ - 1);
        end else if (state == ENTER) begin
            last_granted <= sel;
        end
    end

    assign start = (last_granted == IW'(NUM_IRQ - 1)) ? '0 : last_granted + IW'(1);
`else
    assign start = '0;
`endif

    irq_priority_pick #(
        .NUM_IRQ (NUM_IRQ),
        .IW      (IW)
    ) u_pick (
        .eligible (eligible),
        .start    (start),
        .valid    (pick_valid),
        .idx      (pick_idx)
    );

    // Edge detect and pending latch; a fresh edge outranks the ack clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_q   <= '0;
            pending <= '0;
        end else begin
            irq_q   <= bus.irq_i;
            pending <= (pending & ~ack_c) | rising;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            sel   <= '0;
        end else begin
            state <= state_nxt;
            if (sel_load) begin
                sel <= pick_idx;
            end
        end
    end

    // Trap vector from mtvec; reserved modes fall back to direct
    always_comb begin
        vec_base = {bus.mtvec[31:2], 2'b00};
        case (bus.mtvec[1:0])
            MTVEC_DIRECT:   vector = vec_base;
            MTVEC_VECTORED: vector = vec_base + ((32'(CAUSE_BASE) + 32'(sel)) << 2);
            default:        vector = vec_base;
        endcase
    end

    always_comb begin
        state_nxt        = state;
        sel_load         = 1'b0;
        ack_c            = '0;
        trap_pending_c   = 1'b0;
        redirect_valid_c = 1'b0;
        redirect_pc_c    = '0;
        mepc_wr_c        = 1'b0;
        mepc_wdata_c     = '0;
        mcause_wr_c      = 1'b0;
        mcause_wdata_c   = '0;
        in_handler_c     = 1'b0;

        case (state)
            IDLE: begin
                if (pick_valid) begin
                    state_nxt = WAIT;
                    sel_load  = 1'b1;
                end
            end
            WAIT: begin
                trap_pending_c = 1'b1;
                // Losing eligibility aborts without an ack, source stays pending
                if (!eligible[sel]) begin
                    state_nxt = IDLE;
                end else if (bus.pipe_ready) begin
                    state_nxt = ENTER;
                end
            end
            ENTER: begin
                ack_c            = NUM_IRQ'(1) << sel;
                mepc_wr_c        = 1'b1;
                mepc_wdata_c     = bus.pc_i;
                mcause_wr_c      = 1'b1;
                mcause_wdata_c   = {1'b1, 31'(CAUSE_BASE) + 31'(sel)};
                redirect_valid_c = 1'b1;
                redirect_pc_c    = vector;
                in_handler_c     = 1'b1;
                state_nxt        = HANDLER;
            end
            HANDLER: begin
                in_handler_c = 1'b1;
                if (bus.is_mret) begin
                    state_nxt = RET;
                end
            end
            RET: begin
                redirect_valid_c = 1'b1;
                redirect_pc_c    = bus.mepc_i;
                state_nxt        = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.irq_ack        = ack_c;
    assign bus.trap_pending   = trap_pending_c;
    assign bus.redirect_valid = redirect_valid_c;
    assign bus.redirect_pc    = redirect_pc_c;
    assign bus.mepc_wr        = mepc_wr_c;
    assign bus.mepc_wdata     = mepc_wdata_c;
    assign bus.mcause_wr      = mcause_wr_c;
    assign bus.mcause_wdata   = mcause_wdata_c;
    assign bus.in_handler     = in_handler_c;

endmodule

// File: tb/tb_irq_trap_sequencer.sv
// Scoreboard bench for irq_trap_sequencer: directed cases plus random rounds.
module tb_irq_trap_sequencer;
    import irq_pkg::*;

    localparam int unsigned N  = 4;
    localparam int unsigned CB = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    irq_trap_sequencer_if #(.NUM_IRQ(N)) bus();

    irq_trap_sequencer #(.NUM_IRQ(N), .CAUSE_BASE(CB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [3:0]  ack;
        logic        wr;
        logic [31:0] mepc;
        logic [31:0] cause;
        logic [31:0] pc;
        logic        inh;
    } exp_t;

    exp_t       q[$];
    int         total = 0;
    int         bad   = 0;
    logic [3:0] m_pend;
    int         m_last;
    bit         rand_ready;
    bit         fixed_ready;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops one expectation per redirect pulse
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (bus.redirect_valid === 1'b1) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_redirect: got pc %h want none at %0t", bus.redirect_pc, $time);
                end else begin
                    e = q.pop_front();
                    chk("redirect_pc", bus.redirect_pc, e.pc);
                    chk("irq_ack", 32'(bus.irq_ack), 32'(e.ack));
                    chk("mepc_wr", 32'(bus.mepc_wr), 32'(e.wr));
                    chk("mepc_wdata", bus.mepc_wdata, e.mepc);
                    chk("mcause_wr", 32'(bus.mcause_wr), 32'(e.wr));
                    chk("mcause_wdata", bus.mcause_wdata, e.cause);
                    chk("in_handler", 32'(bus.in_handler), 32'(e.inh));
                end
            end else begin
                chk("idle_strobes", {26'd0, bus.irq_ack, bus.mepc_wr, bus.mcause_wr}, 32'd0);
            end
        end
    end

    // Sole driver of pipe_ready
    initial begin
        bus.pipe_ready = 1'b0;
        forever begin
            @(negedge clk);
            bus.pipe_ready = rand_ready ? 1'($urandom_range(0, 1)) : fixed_ready;
        end
    end

    // Reference arbitration over a set of pending sources
    function automatic int pick(input logic [3:0] p);
`ifdef IRQ_ROUND_ROBIN_EN
        for (int k = 1; k <= int'(N); k++) begin
            int i;
            i = (m_last + k) % int'(N);
            if (p[i]) return i;
        end
`else
        for (int i = 0; i < int'(N); i++) begin
            if (p[i]) return i;
        end
`endif
        return -1;
    endfunction

    function automatic logic [31:0] vec_of(input logic [31:0] tv, input int w);
        logic [31:0] b;
        b = {tv[31:2], 2'b00};
        if (tv[1:0] == 2'b01) b = b + 32'((int'(CB) + w) * 4);
        return b;
    endfunction

    task automatic push_trap(input int w);
        exp_t e;
        e.ack   = 4'b0001 << w;
        e.wr    = 1'b1;
        e.mepc  = bus.pc_i;
        e.cause = 32'h8000_0000 | 32'(int'(CB) + w);
        e.pc    = vec_of(bus.mtvec, w);
        e.inh   = 1'b1;
        q.push_back(e);
    endtask

    task automatic push_ret();
        exp_t e;
        e.ack = '0; e.wr = 1'b0; e.mepc = '0; e.cause = '0;
        e.pc  = bus.mepc_i; e.inh = 1'b0;
        q.push_back(e);
    endtask

    // Drain the model's pending set into expectations; returns trap count
    task automatic plan(output int n);
        int w;
        n = 0;
        while (m_pend != 0) begin
            w = pick(m_pend);
            push_trap(w);
            push_ret();
            m_pend[w] = 1'b0;
            m_last    = w;
            n++;
        end
    endtask

    task automatic pulse_irq(input logic [3:0] mask);
        bus.irq_i = mask;
        @(negedge clk);
        bus.irq_i = '0;
    endtask

    task automatic wait_handler(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (bus.in_handler === 1'b1 && bus.redirect_valid === 1'b0) begin
                ok = 1'b1;
                return;
            end
        end
        total++;
        bad++;
        $display("FAIL handler_timeout: got no HANDLER want HANDLER within 200 cycles");
    endtask

    task automatic serve(input int n);
        bit ok;
        for (int i = 0; i < n; i++) begin
            wait_handler(ok);
            if (!ok) return;
            bus.is_mret = 1'b1;
            @(negedge clk);
            bus.is_mret = 1'b0;
        end
    endtask

    initial begin
        int   n;
        int   lat;
        bit   ok;
        exp_t e;

        rst = 1'b1;
        rand_ready = 1'b0; fixed_ready = 1'b0;
        bus.irq_i = '0; bus.irq_en = '0; bus.glob_ie = 1'b0;
        bus.mtvec = '0; bus.mepc_i = '0; bus.pc_i = '0; bus.is_mret = 1'b0;
        m_pend = '0; m_last = int'(N) - 1;
        #2;
        chk("rst_redirect_valid", 32'(bus.redirect_valid), 32'd0);
        chk("rst_trap_pending", 32'(bus.trap_pending), 32'd0);
        chk("rst_in_handler", 32'(bus.in_handler), 32'd0);
        chk("rst_redirect_pc", bus.redirect_pc, 32'd0);
        chk("rst_mcause_wdata", bus.mcause_wdata, 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        bus.irq_en = 4'hF; bus.glob_ie = 1'b1; fixed_ready = 1'b1;
        repeat (2) @(negedge clk);

        // Direct mode, source 2, with latency checks
        bus.mtvec = 32'h0000_0100; bus.pc_i = 32'h40; bus.mepc_i = 32'h40;
        e = '{ack: 4'b0100, wr: 1'b1, mepc: 32'h40, cause: 32'h8000_0012, pc: 32'h100, inh: 1'b1};
        q.push_back(e);
        e = '{ack: 4'b0000, wr: 1'b0, mepc: 32'h0, cause: 32'h0, pc: 32'h40, inh: 1'b0};
        q.push_back(e);
        m_last = 2;
        bus.irq_i = 4'b0100;
        lat = 0;
        do begin
            @(negedge clk);
            bus.irq_i = '0;
            lat++;
        end while (bus.redirect_valid !== 1'b1 && lat < 20);
        chk("irq_to_redirect_latency", 32'(lat), 32'd3);
        wait_handler(ok);
        bus.is_mret = 1'b1;
        @(negedge clk);
        bus.is_mret = 1'b0;
        chk("mret_redirect_latency", 32'(bus.redirect_valid), 32'd1);
        repeat (3) @(negedge clk);

        // Vectored mode, source 1
        bus.mtvec = 32'h0000_0201; bus.pc_i = 32'h1234; bus.mepc_i = 32'h5678;
        e = '{ack: 4'b0010, wr: 1'b1, mepc: 32'h1234, cause: 32'h8000_0011, pc: 32'h244, inh: 1'b1};
        q.push_back(e);
        push_ret();
        m_last = 1;
        pulse_irq(4'b0010);
        serve(1);
        repeat (3) @(negedge clk);

        // Grant 0 alone, then simultaneous 0 and 3
        bus.mtvec = 32'h0000_0300;
        m_pend = 4'b0001; plan(n); pulse_irq(4'b0001); serve(n);
        repeat (3) @(negedge clk);
        m_pend = 4'b1001; plan(n); pulse_irq(4'b1001); serve(n);
        repeat (3) @(negedge clk);

        // Stall in WAIT, abort via glob_ie, then take the trap
        fixed_ready = 1'b0;
        repeat (2) @(negedge clk);
        m_pend = 4'b0001;
        pulse_irq(4'b0001);
        repeat (6) @(negedge clk);
        chk("stall_trap_pending", 32'(bus.trap_pending), 32'd1);
        bus.glob_ie = 1'b0;
        @(negedge clk);
        chk("abort_trap_pending", 32'(bus.trap_pending), 32'd0);
        repeat (3) @(negedge clk);
        chk("abort_stays_idle", 32'(bus.trap_pending), 32'd0);
        plan(n);
        fixed_ready = 1'b1;
        bus.glob_ie = 1'b1;
        serve(n);
        repeat (3) @(negedge clk);

        // New edge on the acked source during ENTER re-traps
        m_pend = 4'b0100; plan(n);
        m_pend = 4'b0100; plan(n);
        pulse_irq(4'b0100);
        lat = 0;
        while (bus.irq_ack === 4'b0000 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        pulse_irq(4'b0100);
        serve(2);
        repeat (3) @(negedge clk);

        // mret outside HANDLER is ignored
        bus.is_mret = 1'b1;
        @(negedge clk);
        bus.is_mret = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("idle_mret_no_redirect", 32'(bus.redirect_valid), 32'd0);
            @(negedge clk);
        end

        // Random rounds with random pipe_ready stalls
        rand_ready = 1'b1;
        for (int r = 0; r < 40; r++) begin
            bus.mtvec  = $urandom;
            bus.pc_i   = $urandom;
            bus.mepc_i = $urandom;
            m_pend = 4'($urandom_range(1, 15));
            begin
                logic [3:0] mask;
                mask = m_pend;
                plan(n);
                pulse_irq(mask);
            end
            serve(n);
            repeat (4) @(negedge clk);
        end
        rand_ready = 1'b0;
        repeat (3) @(negedge clk);

        // Reset in HANDLER drops everything, including a pending edge
        bus.mtvec = 32'h0000_0400; bus.pc_i = 32'h88;
        push_trap(1);
        pulse_irq(4'b0010);
        wait_handler(ok);
        pulse_irq(4'b1000);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rstH_in_handler", 32'(bus.in_handler), 32'd0);
        chk("rstH_redirect_valid", 32'(bus.redirect_valid), 32'd0);
        chk("rstH_trap_pending", 32'(bus.trap_pending), 32'd0);
        chk("rstH_strobes", {26'd0, bus.irq_ack, bus.mepc_wr, bus.mcause_wr}, 32'd0);
        chk("rstH_redirect_pc", bus.redirect_pc, 32'd0);
        chk("rstH_mepc_wdata", bus.mepc_wdata, 32'd0);
        m_pend = '0; m_last = int'(N) - 1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (10) begin
            @(negedge clk);
            chk("post_rst_no_trap", 32'(bus.trap_pending | bus.in_handler), 32'd0);
        end

        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
